// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RISC-V style control FSM with memory-wait timeout and sticky trap.
// Optional macro BRANCH_EXT_EN enables bne/blt/bge/bltu/bgeu; otherwise only beq is legal.
//
// state    | meaning
// FETCH    | request instruction word, latch IR and advance PC on MemReady
// DECODE   | compute branch/jump target, dispatch on opcode
// MEMADR   | compute load/store address
// MEMREAD  | load data request, wait for MemReady
// MEMWB    | write loaded data to register file
// MEMWRITE | store data request, wait for MemReady
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALU result to register file
// BRANCH   | compare and conditionally redirect PC
// JAL      | redirect PC, link address written in ALUWB
// TRAP     | illegal instruction or memory timeout, held until reset
module multicycle_ctrl #(
  parameter int ALUCTRL_W   = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7,
  input  logic                 Zero,
  input  logic                 Lt,
  input  logic                 Ltu,
  input  logic                 MemReady,
  output logic                 MemReq,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Trap,
  output logic [3:0]           State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  state_t     state, state_nx;
  logic [7:0] wait_cnt;
  logic       timed_out;

  logic       mem_req, pc_write, ir_write, reg_write, mem_write, adr_src, trap;
  logic [1:0] src_a, src_b, res_src, imm_src;
  logic [2:0] alu_ctl;

  logic [2:0] alu_op;
  logic       alu_legal;
  logic       br_legal, br_taken;

  assign timed_out = !MemReady && (wait_cnt >= 8'(MEM_TIMEOUT));

  always_comb begin
    alu_op    = 3'b000;
    alu_legal = 1'b1;
    case (funct3)
      3'b000:  alu_op = (state == S_EXECR && funct7) ? 3'b001 : 3'b000;
      3'b010:  alu_op = 3'b101;
      3'b110:  alu_op = 3'b011;
      3'b111:  alu_op = 3'b010;
      default: alu_legal = 1'b0;
    endcase
  end

`ifdef BRANCH_EXT_EN
  always_comb begin
    br_legal = 1'b1;
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = Zero;
      3'b001:  br_taken = !Zero;
      3'b100:  br_taken = Lt;
      3'b101:  br_taken = !Lt;
      3'b110:  br_taken = Ltu;
      3'b111:  br_taken = !Ltu;
      default: br_legal = 1'b0;
    endcase
  end
`else
  logic unused_flags;
  assign unused_flags = Lt ^ Ltu;
  assign br_legal     = (funct3 == 3'b000);
  assign br_taken     = Zero;
`endif

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    adr_src   = 1'b0;
    src_a     = 2'b00;
    src_b     = 2'b00;
    res_src   = 2'b00;
    imm_src   = 2'b00;
    alu_ctl   = 3'b000;
    trap      = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (MemReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          src_b    = 2'b10;
          res_src  = 2'b10;
          state_nx = S_DECODE;
        end else if (timed_out) begin
          state_nx = S_TRAP;
        end
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_nx = S_MEMADR;
          7'b0110011:             state_nx = S_EXECR;
          7'b0010011:             state_nx = S_EXECI;
          7'b1100011:             state_nx = S_BRANCH;
          7'b1101111:             state_nx = S_JAL;
          default:                state_nx = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a = 2'b10;
        src_b = 2'b01;
        // op[5] separates store (0100011) from load (0000011)
        if (op[5]) begin
          imm_src  = 2'b01;
          state_nx = S_MEMWRITE;
        end else begin
          state_nx = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (MemReady)       state_nx = S_MEMWB;
        else if (timed_out) state_nx = S_TRAP;
      end
      S_MEMWB: begin
        res_src   = 2'b01;
        reg_write = 1'b1;
        state_nx  = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (MemReady)       state_nx = S_FETCH;
        else if (timed_out) state_nx = S_TRAP;
      end
      S_EXECR, S_EXECI: begin
        src_a    = 2'b10;
        src_b    = (state == S_EXECI) ? 2'b01 : 2'b00;
        alu_ctl  = alu_op;
        state_nx = alu_legal ? S_ALUWB : S_TRAP;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_nx  = S_FETCH;
      end
      S_BRANCH: begin
        src_a    = 2'b10;
        alu_ctl  = 3'b001;
        imm_src  = 2'b10;
        pc_write = br_legal && br_taken;
        state_nx = br_legal ? S_FETCH : S_TRAP;
      end
      S_JAL: begin
        src_a    = 2'b01;
        src_b    = 2'b10;
        imm_src  = 2'b11;
        pc_write = 1'b1;
        state_nx = S_ALUWB;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_nx = S_TRAP;
      end
    endcase
    // outputs are Mealy on MemReady, so reset has to gate them directly
    if (!rst_n) begin
      mem_req   = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      adr_src   = 1'b0;
      src_a     = 2'b00;
      src_b     = 2'b00;
      res_src   = 2'b00;
      imm_src   = 2'b00;
      alu_ctl   = 3'b000;
      trap      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
    end else begin
      state <= state_nx;
      if (state_nx != state || !mem_req || MemReady) wait_cnt <= 8'd0;
      else                                           wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign MemReq     = mem_req;
  assign PCWrite    = pc_write;
  assign IRWrite    = ir_write;
  assign RegWrite   = reg_write;
  assign MemWrite   = mem_write;
  assign AdrSrc     = adr_src;
  assign ALUSrcA    = src_a;
  assign ALUSrcB    = src_b;
  assign ResultSrc  = res_src;
  assign ImmSrc     = imm_src;
  assign ALUControl = ALUCTRL_W'(alu_ctl);
  assign Trap       = trap;
  assign State      = state;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter ALUCTRL_W, default 3: ALUControl width, legal range 3..8; bits above [2:0] SHALL be driven 0.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum cycles a memory request waits for MemReady before trapping, legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 op  input  7  instruction opcode, valid from DECODE onward.
REQ-006 funct3  input  3  instruction funct3.
REQ-007 funct7  input  1  instruction bit 30.
REQ-008 Zero, Lt, Ltu  input  1 each  ALU flags (equal, signed-less, unsigned-less) from the previous ALU cycle.
REQ-009 MemReady  input  1  memory handshake completion.
REQ-010 MemReq  output  1  memory access request.
REQ-011 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  output  1 each  datapath enables/selects.
REQ-012 ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  output  2 each  datapath selects.
REQ-013 ALUControl  output  ALUCTRL_W  ALU operation.
REQ-014 Trap  output  1  sticky illegal-instruction/timeout flag.
REQ-015 State  output  4  current FSM state, for debug.

Function
REQ-016 States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=15; 11-14 SHALL transition to TRAP.
REQ-017 FETCH: MemReq=1, AdrSrc=0; on MemReady=1 assert IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=000, ResultSrc=10, next DECODE; otherwise hold FETCH.
REQ-018 DECODE: ALUSrcA=01, ALUSrcB=01, ALUControl=000; next by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BRANCH, 1101111->JAL, any other op->TRAP.
REQ-019 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUControl=000; ImmSrc=00 for lw (next MEMREAD), 01 for sw (next MEMWRITE).
REQ-020 MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00; on MemReady=1 next MEMWB. MEMWB: ResultSrc=01, RegWrite=1, next FETCH.
REQ-021 MEMWRITE: MemReq=1, AdrSrc=1, MemWrite=1; on MemReady=1 next FETCH.
REQ-022 EXECR: ALUSrcA=10, ALUSrcB=00. EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00. Both next ALUWB. ALUWB: ResultSrc=00, RegWrite=1, next FETCH.
REQ-023 ALU decode (EXECR/EXECI): funct3 000->000 (add), or 001 (sub) only when EXECR and funct7=1; 010->101 (slt); 110->011 (or); 111->010 (and); other funct3->TRAP instead of ALUWB.
REQ-024 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl=001, ResultSrc=00, ImmSrc=10; PCWrite=1 iff taken; next FETCH.
REQ-025 JAL: ALUSrcA=01, ALUSrcB=10, ALUControl=000, ResultSrc=00, ImmSrc=11, PCWrite=1, next ALUWB.
REQ-026 Wait counter: 8-bit; cleared on entry to FETCH/MEMREAD/MEMWRITE and on MemReady=1; increments each cycle MemReq=1 and MemReady=0; reaching MEM_TIMEOUT forces TRAP next cycle.
REQ-027 TRAP: all enables and MemReq 0, Trap=1; state held until reset.
REQ-028 Outputs not listed for a state SHALL be 0; MemWrite, RegWrite, PCWrite, IRWrite never asserted with MemReady low in a MemReq state except MemWrite in MEMWRITE.

Reset
REQ-029 rst_n=0 SHALL immediately force State=FETCH, wait counter=0, Trap=0, and all outputs 0 (including MemReq) while asserted.
REQ-030 Reset mid-access SHALL abandon the access; first cycle after release SHALL be FETCH with MemReq=1.

Configuration
REQ-031 Macro BRANCH_EXT_EN: defined -> BRANCH taken for funct3 000 Zero, 001 !Zero, 100 Lt, 101 !Lt, 110 Ltu, 111 !Ltu; 010/011 -> TRAP.
REQ-032 Without BRANCH_EXT_EN: only funct3=000 (taken iff Zero) legal; any other funct3 in BRANCH -> TRAP, Lt/Ltu ignored.

Verification
REQ-033 lw, MemReady=1 always -> states 0,1,2,3,4,0; RegWrite=1 only in MEMWB; ResultSrc=01 there.
REQ-034 sw with MemReady low 3 cycles in MEMWRITE -> MemWrite=1 held 4 cycles, then FETCH; no Trap.
REQ-035 R-type funct3=000 funct7=1 -> ALUControl=001 in EXECR; I-type same fields -> ALUControl=000.
REQ-036 beq Zero=1 -> PCWrite=1 in BRANCH; bne (funct3=001) Zero=0 -> taken with BRANCH_EXT_EN, Trap=1 without.
REQ-037 MemReady held 0 in FETCH, MEM_TIMEOUT=15 -> State=15, Trap=1 after 16 cycles; op=1111111 -> TRAP from DECODE.
REQ-038 rst_n pulsed low during MEMREAD -> all outputs 0 immediately; after release State=0, MemReq=1.
